apb3_timer: RTL and testbench

//  APB3 slave timer that sits directly downstream of the AHB-to-APB3 bridge, on its PSEL/PENABLE/PADDR bus.
//  It is a 32-bit down-counter with prescaler, periodic/one-shot modes, a level interrupt and a register interface.

---
 rtl/apb3_timer_pkg.sv | 14 +
 rtl/apb3_timer_core.sv | 38 +++
 rtl/apb3_timer.sv | 96 +++++++++
 tb/tb_apb3_timer.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb3_timer_pkg.sv
// apb3_timer_pkg: register offsets, CTRL bit indices and APB FSM encoding for apb3_timer
package apb3_timer_pkg;
    localparam int OFF_LOAD     = 'h00;
    localparam int OFF_VALUE    = 'h04;
    localparam int OFF_CTRL     = 'h08;
    localparam int OFF_PRESCALE = 'h0C;
    localparam int OFF_INTCLR   = 'h10;
    localparam int OFF_RIS      = 'h14;
    localparam int OFF_MIS      = 'h18;
    localparam int CTRL_EN      = 0;
    localparam int CTRL_IE      = 1;
    localparam int CTRL_ONESHOT = 2;
    typedef enum logic {IDLE = 1'b0, RWAIT = 1'b1} apb_state_t;
endpackage

// File: rtl/apb3_timer_core.sv
// apb3_timer_core: prescaler, 32-bit down-counter and raw interrupt status
module apb3_timer_core
    import apb3_timer_pkg::*;
#(
    parameter int PRE_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_we,
    input  logic [31:0]      load_val,
    input  logic [31:0]      load,
    input  logic             en,
    input  logic             oneshot,
    input  logic [PRE_W-1:0] prescale,
    input  logic             intclr,
    output logic [31:0]      value,
    output logic             ris,
    output logic             en_clr
);
    logic [PRE_W-1:0] pcnt;
    logic             tick;
    logic             expire;
    // a LOAD write restarts the prescaler and swallows any tick on the same edge
    assign tick   = en && pcnt == prescale && !load_we;
    assign expire = tick && value == '0;
    assign en_clr = expire && oneshot;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt  <= '0;
            value <= '0;
            ris   <= 1'b0;
        end else begin
            pcnt  <= (load_we || tick) ? '0 : en ? pcnt + 1'b1 : pcnt;
            value <= load_we ? load_val : expire ? load : tick ? value - 32'd1 : value;
            ris   <= expire ? 1'b1 : intclr ? 1'b0 : ris;
        end
    end
endmodule

// File: rtl/apb3_timer.sv
// apb3_timer: APB3 slave wrapping a prescaled down-counter with periodic/one-shot modes and interrupt
module apb3_timer
    import apb3_timer_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int PRE_W  = 8
) (
    input  logic              HCLK,
    input  logic              HRESETN,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic              TIMINT
);
    apb_state_t       state, state_nxt;
    logic [ADDR_W-1:0] addr;
    logic              access, wr_en, rd_cap, addr_ok, rd_err;
    logic              we_load, we_ctrl, we_pre, we_clr;
    logic [31:0]       rdata, load, value;
    logic              en, ie, oneshot, ris, en_clr;
    logic [PRE_W-1:0]  prescale;
    assign addr    = PADDR & ~ADDR_W'(3);
    assign access  = PSEL && PENABLE;
    assign we_load = wr_en && addr == ADDR_W'(OFF_LOAD);
    assign we_ctrl = wr_en && addr == ADDR_W'(OFF_CTRL);
    assign we_pre  = wr_en && addr == ADDR_W'(OFF_PRESCALE);
    assign we_clr  = wr_en && addr == ADDR_W'(OFF_INTCLR);
    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) state <= IDLE;
        else          state <= state_nxt;
    end
    always_comb begin
        state_nxt = (state == IDLE && access && !PWRITE) ? RWAIT : IDLE;
    end
    always_comb begin
        wr_en   = state == IDLE && access && PWRITE;
        rd_cap  = state == IDLE && access && !PWRITE;
        PREADY  = state == RWAIT || wr_en;
        PSLVERR = state == RWAIT ? rd_err : wr_en && !addr_ok;
    end
    always_comb begin
        rdata   = '0;
        addr_ok = 1'b1;
        case (addr)
            ADDR_W'(OFF_LOAD):     rdata = load;
            ADDR_W'(OFF_VALUE):    rdata = value;
            ADDR_W'(OFF_CTRL):     rdata = {29'b0, oneshot, ie, en};
            ADDR_W'(OFF_PRESCALE): rdata = 32'(prescale);
            ADDR_W'(OFF_INTCLR):   rdata = '0;
            ADDR_W'(OFF_RIS):      rdata = {31'b0, ris};
            ADDR_W'(OFF_MIS):      rdata = {31'b0, ris & ie};
            default:               addr_ok = 1'b0;
        endcase
    end
    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            PRDATA   <= '0;
            rd_err   <= 1'b0;
            load     <= '0;
            en       <= 1'b0;
            ie       <= 1'b0;
            oneshot  <= 1'b0;
            prescale <= '0;
            TIMINT   <= 1'b0;
        end else begin
            PRDATA   <= rd_cap ? rdata : PRDATA;
            rd_err   <= rd_cap ? !addr_ok : rd_err;
            load     <= we_load ? PWDATA : load;
            // a bus write to CTRL overrides a one-shot expiry clearing EN
            en       <= we_ctrl ? PWDATA[CTRL_EN] : en_clr ? 1'b0 : en;
            ie       <= we_ctrl ? PWDATA[CTRL_IE] : ie;
            oneshot  <= we_ctrl ? PWDATA[CTRL_ONESHOT] : oneshot;
            prescale <= we_pre ? PWDATA[PRE_W-1:0] : prescale;
            TIMINT   <= ris & ie;
        end
    end
    apb3_timer_core #(.PRE_W(PRE_W)) u_core (
        .clk      (HCLK),
        .rst_n    (HRESETN),
        .load_we  (we_load),
        .load_val (PWDATA),
        .load     (load),
        .en       (en),
        .oneshot  (oneshot),
        .prescale (prescale),
        .intclr   (we_clr),
        .value    (value),
        .ris      (ris),
        .en_clr   (en_clr)
    );
endmodule

// File: tb/tb_apb3_timer.sv
// tb_apb3_timer: randomized APB stimulus checked against a closed-form timer model
module tb_apb3_timer;
    localparam logic [7:0] A_LOAD = 8'h00, A_VALUE = 8'h04, A_CTRL = 8'h08, A_PRE = 8'h0C;
    localparam logic [7:0] A_CLR = 8'h10, A_RIS = 8'h14, A_MIS = 8'h18;
    logic        HCLK = 0, HRESETN = 0, PSEL = 0, PENABLE = 0, PWRITE = 0;
    logic [7:0]  PADDR = 0;
    logic [31:0] PWDATA = 0;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR, TIMINT;
    int cyc = 0;
    int n_chk = 0, n_fail = 0;
    int m_e, m_l, m_p, m_c;
    bit m_os, m_ie;

    apb3_timer dut (
        .HCLK(HCLK), .HRESETN(HRESETN), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
        .PSLVERR(PSLVERR), .TIMINT(TIMINT)
    );

    always #5 HCLK = ~HCLK;
    always @(posedge HCLK) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    // Model: the timer was enabled with a fresh prescaler at edge m_e; ticks fall every m_p+1 edges.
    function automatic int ticks(int s);
        return s < m_e ? 0 : (s - m_e) / (m_p + 1);
    endfunction
    function automatic logic [31:0] exp_value(int s);
        int n;
        n = ticks(s);
        if (m_os) return 32'(n > m_l ? m_l : m_l - n);
        return 32'(m_l - n % (m_l + 1));
    endfunction
    function automatic bit exp_ris(int s);
        int k, x;
        k = ticks(s) / (m_l + 1);
        if (k == 0) return 1'b0;
        if (m_os) k = 1;
        x = m_e + k * (m_l + 1) * (m_p + 1);
        return x >= m_c || m_c > s;
    endfunction
    function automatic bit exp_en(int s);
        return !(m_os && ticks(s) > m_l);
    endfunction

    task automatic apb_write(input logic [7:0] a, input logic [31:0] d, output logic rdy, output logic err);
        PSEL = 1; PWRITE = 1; PADDR = a; PWDATA = d; PENABLE = 0;
        @(posedge HCLK); #1 PENABLE = 1;
        @(negedge HCLK); rdy = PREADY; err = PSLVERR;
        @(posedge HCLK); #1 PSEL = 0; PENABLE = 0; PWRITE = 0;
    endtask
    task automatic apb_read(input logic [7:0] a, output logic [31:0] d, output logic err,
                            output logic rdy1, output logic rdy2, output int s);
        PSEL = 1; PWRITE = 0; PADDR = a; PENABLE = 0;
        @(posedge HCLK); #1 PENABLE = 1; s = cyc;
        @(negedge HCLK); rdy1 = PREADY;
        @(posedge HCLK);
        @(negedge HCLK); rdy2 = PREADY; d = PRDATA; err = PSLVERR;
        @(posedge HCLK); #1 PSEL = 0; PENABLE = 0;
    endtask
    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        logic r, e;
        apb_write(a, d, r, e);
    endtask
    task automatic rd(input logic [7:0] a, output logic [31:0] d, output int s);
        logic e, r1, r2;
        apb_read(a, d, e, r1, r2, s);
    endtask
    task automatic wait_until(input int t);
        while (cyc < t) begin @(posedge HCLK); #1; end
    endtask
    task automatic configure(input int l, input int p, input bit os, input bit ie);
        wr(A_CTRL, 0);
        wr(A_CLR, 0);
        wr(A_PRE, 32'(p));
        wr(A_LOAD, 32'(l));
        wr(A_CTRL, {29'b0, os, ie, 1'b1});
        m_e = cyc; m_l = l; m_p = p; m_os = os; m_ie = ie; m_c = -1;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        logic e, r1, r2;
        int s;
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        n_chk++;
        if ({PRDATA, PREADY, PSLVERR, TIMINT} !== 35'b0) begin
            n_fail++; $display("FAIL reset_outputs: got %h want 0", {PRDATA, PREADY, PSLVERR, TIMINT});
        end
        HRESETN = 1;
        @(posedge HCLK); #1;
        for (int a = 0; a <= 'h18; a += 4) begin
            apb_read(8'(a), d, e, r1, r2, s);
            n_chk++;
            if ({d, e, r1, r2} !== {32'h0, 1'b0, 1'b0, 1'b1}) begin
                n_fail++; $display("FAIL reset_read[%0h]: got data=%h err=%b rdy1=%b rdy2=%b want 0/0/0/1", a, d, e, r1, r2);
            end
        end
    endtask

    task automatic test_periodic;
        logic [31:0] d;
        int s, t, w;
        configure(3, 0, 0, 1);
        for (int i = 0; i < 12; i++) begin
            @(posedge HCLK); #1 t = cyc;
            @(negedge HCLK);
            n_chk++;
            if (TIMINT !== (m_ie & exp_ris(t - 1))) begin
                n_fail++; $display("FAIL periodic_timint t=%0d: got %b want %b", t - m_e, TIMINT, exp_ris(t - 1));
            end
        end
        @(posedge HCLK); #1;
        for (int i = 0; i < 5; i++) begin
            rd(A_VALUE, d, s);
            n_chk++;
            if (d !== exp_value(s)) begin
                n_fail++; $display("FAIL periodic_value s=%0d: got %0d want %0d", s - m_e, d, exp_value(s));
            end
        end
        w = cyc + 2;
        while ((w - m_e) % 4 != 1) w++;
        wait_until(w - 2);
        wr(A_CLR, 1);
        m_c = w;
        @(negedge HCLK);
        n_chk++;
        if (TIMINT !== exp_ris(w - 1)) begin
            n_fail++; $display("FAIL intclr_timint_same: got %b want %b", TIMINT, exp_ris(w - 1));
        end
        @(posedge HCLK); #1;
        @(negedge HCLK);
        n_chk++;
        if (TIMINT !== exp_ris(w)) begin
            n_fail++; $display("FAIL intclr_timint_next: got %b want %b", TIMINT, exp_ris(w));
        end
        rd(A_RIS, d, s);
        n_chk++;
        if (d !== {31'b0, exp_ris(s)}) begin
            n_fail++; $display("FAIL intclr_ris: got %0d want %0d", d, exp_ris(s));
        end
        w = cyc + 2;
        while ((w - m_e) % 4 != 0) w++;
        wait_until(w - 2);
        wr(A_CLR, 1);
        m_c = w;
        rd(A_RIS, d, s);
        n_chk++;
        if (d !== {31'b0, exp_ris(s)}) begin
            n_fail++; $display("FAIL intclr_collision_ris: got %0d want %0d", d, exp_ris(s));
        end
    endtask

    task automatic test_oneshot;
        logic [31:0] d;
        int s;
        configure(2, 4, 1, 1);
        for (int i = 0; i < 8; i++) begin
            rd(A_VALUE, d, s);
            n_chk++;
            if (d !== exp_value(s)) begin
                n_fail++; $display("FAIL oneshot_value s=%0d: got %0d want %0d", s - m_e, d, exp_value(s));
            end
            rd(A_RIS, d, s);
            n_chk++;
            if (d !== {31'b0, exp_ris(s)}) begin
                n_fail++; $display("FAIL oneshot_ris s=%0d: got %0d want %0d", s - m_e, d, exp_ris(s));
            end
        end
        rd(A_CTRL, d, s);
        n_chk++;
        if (d !== {29'b0, m_os, m_ie, exp_en(s)}) begin
            n_fail++; $display("FAIL oneshot_ctrl: got %h want %h", d, {29'b0, m_os, m_ie, exp_en(s)});
        end
        @(negedge HCLK);
        n_chk++;
        if (TIMINT !== 1'b1) begin
            n_fail++; $display("FAIL oneshot_timint: got %b want 1", TIMINT);
        end
        @(posedge HCLK); #1;
    endtask

    task automatic test_collisions;
        logic [31:0] d;
        int s, w;
        configure(1, 0, 1, 1);
        wr(A_CTRL, 32'h7);
        m_e = cyc;
        rd(A_CTRL, d, s);
        n_chk++;
        if (d !== {29'b0, m_os, m_ie, exp_en(s)}) begin
            n_fail++; $display("FAIL ctrl_collision: got %h want %h", d, {29'b0, m_os, m_ie, exp_en(s)});
        end
        configure(5, 3, 0, 1);
        w = m_e + 4;
        wait_until(w - 2);
        wr(A_LOAD, 9);
        m_e = w; m_l = 9;
        for (int i = 0; i < 2; i++) begin
            rd(A_VALUE, d, s);
            n_chk++;
            if (d !== exp_value(s)) begin
                n_fail++; $display("FAIL load_collision[%0d]: got %0d want %0d", i, d, exp_value(s));
            end
        end
    endtask

    task automatic test_errors;
        logic [31:0] d;
        logic r, e, r1, r2;
        int s;
        wr(A_CTRL, 0);
        apb_write(A_LOAD, 32'h55, r, e);
        n_chk++;
        if ({r, e} !== 2'b10) begin
            n_fail++; $display("FAIL write_ok: got rdy=%b err=%b want 1/0", r, e);
        end
        wr(A_PRE, 3);
        apb_write(8'h20, 32'hDEAD, r, e);
        n_chk++;
        if ({r, e} !== 2'b11) begin
            n_fail++; $display("FAIL write_unmapped: got rdy=%b err=%b want 1/1", r, e);
        end
        apb_write(A_VALUE, 32'h1234, r, e);
        n_chk++;
        if ({r, e} !== 2'b10) begin
            n_fail++; $display("FAIL write_ro: got rdy=%b err=%b want 1/0", r, e);
        end
        rd(A_VALUE, d, s);
        n_chk++;
        if (d !== 32'h55) begin
            n_fail++; $display("FAIL value_after_ro_write: got %h want 55", d);
        end
        rd(A_LOAD, d, s);
        n_chk++;
        if (d !== 32'h55) begin
            n_fail++; $display("FAIL load_after_bad_write: got %h want 55", d);
        end
        rd(A_PRE, d, s);
        n_chk++;
        if (d !== 32'h3) begin
            n_fail++; $display("FAIL prescale_readback: got %h want 3", d);
        end
        rd(A_CLR, d, s);
        n_chk++;
        if (d !== 32'h0) begin
            n_fail++; $display("FAIL intclr_read: got %h want 0", d);
        end
        apb_read(8'h1C, d, e, r1, r2, s);
        n_chk++;
        if ({d, e, r1, r2} !== {32'h0, 1'b1, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL read_unmapped: got data=%h err=%b rdy1=%b rdy2=%b want 0/1/0/1", d, e, r1, r2);
        end
    endtask

    task automatic test_random;
        logic [31:0] d;
        int s, t;
        for (int it = 0; it < 5; it++) begin
            configure($urandom_range(0, 6), $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            for (int j = 0; j < 4; j++) begin
                repeat ($urandom_range(0, 7)) begin @(posedge HCLK); #1; end
                t = cyc;
                @(negedge HCLK);
                n_chk++;
                if (TIMINT !== (m_ie & exp_ris(t - 1))) begin
                    n_fail++; $display("FAIL rand_timint: got %b want %b", TIMINT, m_ie & exp_ris(t - 1));
                end
                rd(A_VALUE, d, s);
                n_chk++;
                if (d !== exp_value(s)) begin
                    n_fail++; $display("FAIL rand_value L=%0d P=%0d os=%0d: got %0d want %0d", m_l, m_p, m_os, d, exp_value(s));
                end
                rd(A_MIS, d, s);
                n_chk++;
                if (d !== {31'b0, m_ie & exp_ris(s)}) begin
                    n_fail++; $display("FAIL rand_mis: got %0d want %0d", d, m_ie & exp_ris(s));
                end
                rd(A_CTRL, d, s);
                n_chk++;
                if (d !== {29'b0, m_os, m_ie, exp_en(s)}) begin
                    n_fail++; $display("FAIL rand_ctrl: got %h want %h", d, {29'b0, m_os, m_ie, exp_en(s)});
                end
            end
        end
    endtask

    task automatic test_reset_rwait;
        logic [31:0] d;
        logic e, r1, r2;
        int s;
        wr(A_CTRL, 0);
        wr(A_LOAD, 32'hA5A5);
        PSEL = 1; PWRITE = 0; PADDR = A_LOAD; PENABLE = 0;
        @(posedge HCLK); #1 PENABLE = 1;
        @(posedge HCLK); #2;
        n_chk++;
        if ({PREADY, PRDATA} !== {1'b1, 32'hA5A5}) begin
            n_fail++; $display("FAIL rwait_before_reset: got rdy=%b data=%h want 1/a5a5", PREADY, PRDATA);
        end
        HRESETN = 0;
        #1;
        n_chk++;
        if ({PRDATA, PREADY, PSLVERR, TIMINT} !== 35'b0) begin
            n_fail++; $display("FAIL rwait_async_reset: got %h want 0", {PRDATA, PREADY, PSLVERR, TIMINT});
        end
        PSEL = 0; PENABLE = 0;
        @(negedge HCLK); HRESETN = 1;
        @(posedge HCLK); #1;
        apb_read(A_LOAD, d, e, r1, r2, s);
        n_chk++;
        if ({d, e, r1, r2} !== {32'h0, 1'b0, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL after_reset_read: got data=%h err=%b rdy1=%b rdy2=%b want 0/0/0/1", d, e, r1, r2);
        end
    endtask

    initial begin
        test_reset;
        test_periodic;
        test_oneshot;
        test_collisions;
        test_errors;
        test_random;
        test_reset_rwait;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
